// File: rtl/text_ctrl_pkg.sv
// Shared constants, control-character codes and FSM state type for the
// UART-to-text-RAM cursor controller.
package text_ctrl_pkg;

    localparam int ROWS = 4;
    localparam int COLS = 32;

    localparam logic [7:0] CH_LF       = 8'h0A;
    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        IDLE,
        PUT,
        CLR_ROW,
        CLR_ALL
    } state_t;

endpackage

// File: rtl/byte_hold_reg.sv
// One-entry receive buffer: presents either the held byte or the live strobe
// to the controller, and flags bytes lost while the entry is occupied.
module byte_hold_reg (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       take,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       overrun
);

    logic       hold_vld;
    logic [7:0] hold_data;

    // The held byte always has priority so arrival order is preserved.
    assign out_valid = hold_vld | rx_valid;
    assign out_data  = hold_vld ? hold_data : rx_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_vld <= 1'b0;
            overrun  <= 1'b0;
        end else if (hold_vld) begin
            if (take)
                hold_vld <= rx_valid;
            else if (rx_valid)
                overrun <= 1'b1;
        end else if (rx_valid && !take) begin
            hold_vld <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rx_valid && (hold_vld ? take : !take))
            hold_data <= rx_data;
    end

endmodule

// File: rtl/text_cursor_ctrl.sv
// Cursor/FSM controller writing received characters into the 4x32 text RAM,
// handling LF/CR, BS and FF, with row and full-screen clears.
module text_cursor_ctrl
    import text_ctrl_pkg::*;
#(
    parameter int         COL_OFFSET     = 24,
    parameter bit         CLEAR_ON_RESET = 1'b1,
    parameter logic [7:0] FILL_CHAR      = 8'h20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       ram_we,
    output logic [1:0] ram_row,
    output logic [4:0] ram_col,
    output logic [7:0] ram_wdata,
    output logic [1:0] cur_row,
    output logic [4:0] cur_col,
    output logic       busy,
    output logic       overrun
);

    localparam logic [4:0] COL_OFF5 = 5'(COL_OFFSET);
    localparam logic [4:0] COL_LAST = 5'(COLS - 1);
    localparam logic [6:0] CNT_LAST = 7'(ROWS * COLS - 1);

    function automatic logic [4:0] phys(input logic [4:0] c);
        return c + COL_OFF5;
    endfunction

    state_t     state, state_nx;
    logic [6:0] cnt, cnt_nx, cnt_inc;
    logic [1:0] row_nx;
    logic [4:0] col_nx;
    logic       put_adv, adv_nx;
    logic       we_nx;
    logic [1:0] wrow_nx;
    logic [4:0] wcol_nx;
    logic [7:0] wdata_nx;
    logic       in_valid;
    logic [7:0] in_data;

    byte_hold_reg u_hold (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .take      (state == IDLE),
        .out_valid (in_valid),
        .out_data  (in_data),
        .overrun   (overrun)
    );

    assign busy    = (state != IDLE);
    assign cnt_inc = cnt + 7'd1;

    // Next-state logic also selects the write that will be on the RAM port
    // during the next cycle, so every RAM output comes straight from a flop.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        row_nx   = cur_row;
        col_nx   = cur_col;
        adv_nx   = put_adv;
        we_nx    = 1'b0;
        wrow_nx  = ram_row;
        wcol_nx  = ram_col;
        wdata_nx = ram_wdata;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_data >= CH_PRINT_LO && in_data <= CH_PRINT_HI) begin
                        state_nx = PUT;
                        adv_nx   = 1'b1;
                        we_nx    = 1'b1;
                        wrow_nx  = cur_row;
                        wcol_nx  = phys(cur_col);
                        wdata_nx = in_data;
                    end else if (in_data == CH_LF || in_data == CH_CR) begin
                        state_nx = CLR_ROW;
                        cnt_nx   = 7'd0;
                        row_nx   = cur_row + 2'd1;
                        col_nx   = 5'd0;
                        we_nx    = 1'b1;
                        wrow_nx  = cur_row + 2'd1;
                        wcol_nx  = phys(5'd0);
                        wdata_nx = FILL_CHAR;
                    end else if (in_data == CH_BS) begin
                        if (cur_col != 5'd0) begin
                            state_nx = PUT;
                            adv_nx   = 1'b0;
                            col_nx   = cur_col - 5'd1;
                            we_nx    = 1'b1;
                            wrow_nx  = cur_row;
                            wcol_nx  = phys(cur_col - 5'd1);
                            wdata_nx = FILL_CHAR;
                        end
                    end else if (in_data == CH_FF) begin
                        state_nx = CLR_ALL;
                        cnt_nx   = 7'd0;
                        we_nx    = 1'b1;
                        wrow_nx  = 2'd0;
                        wcol_nx  = phys(5'd0);
                        wdata_nx = FILL_CHAR;
                    end
                end
            end
            PUT: begin
                state_nx = IDLE;
                if (put_adv) begin
                    if (cur_col != COL_LAST) begin
                        col_nx = cur_col + 5'd1;
                    end else begin
                        state_nx = CLR_ROW;
                        cnt_nx   = 7'd0;
                        row_nx   = cur_row + 2'd1;
                        col_nx   = 5'd0;
                        we_nx    = 1'b1;
                        wrow_nx  = cur_row + 2'd1;
                        wcol_nx  = phys(5'd0);
                        wdata_nx = FILL_CHAR;
                    end
                end
            end
            CLR_ROW: begin
                if (cnt[4:0] == COL_LAST) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx   = cnt_inc;
                    we_nx    = 1'b1;
                    wrow_nx  = cur_row;
                    wcol_nx  = phys(cnt_inc[4:0]);
                    wdata_nx = FILL_CHAR;
                end
            end
            CLR_ALL: begin
                // After reset the first cycle carries no write; the sweep
                // starts from index 0 on the following cycle.
                if (!ram_we) begin
                    cnt_nx   = 7'd0;
                    we_nx    = 1'b1;
                    wrow_nx  = 2'd0;
                    wcol_nx  = phys(5'd0);
                    wdata_nx = FILL_CHAR;
                end else if (cnt == CNT_LAST) begin
                    state_nx = IDLE;
                    row_nx   = 2'd0;
                    col_nx   = 5'd0;
                end else begin
                    cnt_nx   = cnt_inc;
                    we_nx    = 1'b1;
                    wrow_nx  = cnt_inc[6:5];
                    wcol_nx  = phys(cnt_inc[4:0]);
                    wdata_nx = FILL_CHAR;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CLEAR_ON_RESET ? CLR_ALL : IDLE;
            cnt       <= 7'd0;
            put_adv   <= 1'b0;
            cur_row   <= 2'd0;
            cur_col   <= 5'd0;
            ram_we    <= 1'b0;
            ram_row   <= 2'd0;
            ram_col   <= 5'd0;
            ram_wdata <= 8'd0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            put_adv   <= adv_nx;
            cur_row   <= row_nx;
            cur_col   <= col_nx;
            ram_we    <= we_nx;
            ram_row   <= wrow_nx;
            ram_col   <= wcol_nx;
            ram_wdata <= wdata_nx;
        end
    end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Randomized + directed bench: a screen/cursor reference model queues expected
// RAM writes, a monitor pops and compares them whenever ram_we is high.
module tb_text_cursor_ctrl;

    typedef struct packed {
        logic [1:0] r;
        logic [4:0] c;
        logic [7:0] d;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       ram_we;
    logic [1:0] ram_row;
    logic [4:0] ram_col;
    logic [7:0] ram_wdata;
    logic [1:0] cur_row;
    logic [4:0] cur_col;
    logic       busy;
    logic       overrun;

    int  n_cmp = 0;
    int  n_fail = 0;
    wr_t exp_q[$];
    int  mrow = 0;
    int  mcol = 0;

    text_cursor_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .ram_we    (ram_we),
        .ram_row   (ram_row),
        .ram_col   (ram_col),
        .ram_wdata (ram_wdata),
        .cur_row   (cur_row),
        .cur_col   (cur_col),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Screen model: physical column is the logical one shifted by 24, mod 32.
    task automatic push_wr(input int r, input int c, input logic [7:0] d);
        wr_t w;
        w.r = 2'(r);
        w.c = 5'((c + 24) % 32);
        w.d = d;
        exp_q.push_back(w);
    endtask

    task automatic clear_row(input int r);
        for (int c = 0; c < 32; c++) push_wr(r, c, 8'h20);
    endtask

    task automatic clear_all();
        for (int r = 0; r < 4; r++) clear_row(r);
    endtask

    // Applies one accepted byte to the model; reports how many cycles the
    // controller stays busy and whether a write appears on the next cycle.
    task automatic model_byte(input logic [7:0] b, output int busy_cyc, output bit wr_now);
        busy_cyc = 0;
        wr_now = 1'b0;
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_wr(mrow, mcol, b);
            busy_cyc = 1;
            wr_now = 1'b1;
            if (mcol == 31) begin
                mcol = 0;
                mrow = (mrow + 1) % 4;
                clear_row(mrow);
                busy_cyc += 32;
            end else begin
                mcol++;
            end
        end else if (b == 8'h0A || b == 8'h0D) begin
            mcol = 0;
            mrow = (mrow + 1) % 4;
            clear_row(mrow);
            busy_cyc = 32;
            wr_now = 1'b1;
        end else if (b == 8'h08) begin
            if (mcol > 0) begin
                mcol--;
                push_wr(mrow, mcol, 8'h20);
                busy_cyc = 1;
                wr_now = 1'b1;
            end
        end else if (b == 8'h0C) begin
            clear_all();
            mrow = 0;
            mcol = 0;
            busy_cyc = 128;
            wr_now = 1'b1;
        end
    endtask

    task automatic check_idle_cursor();
        check("busy_low", busy, 0);
        check("cur_row", cur_row, mrow);
        check("cur_col", cur_col, mcol);
    endtask

    task automatic send(input logic [7:0] b);
        int bc;
        bit wr;
        model_byte(b, bc, wr);
        rx_data = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        check("we_latency", ram_we, wr);
        repeat (bc) @(posedge clk);
        #1;
        check_idle_cursor();
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ram_write: unexpected write r%0d c%0d d%0h at %0t",
                         ram_row, ram_col, ram_wdata, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if ({ram_row, ram_col, ram_wdata} !== e) begin
                    n_fail++;
                    $display("FAIL ram_write: got r%0d c%0d d%0h expected r%0d c%0d d%0h at %0t",
                             ram_row, ram_col, ram_wdata, e.r, e.c, e.d, $time);
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d writes pending", exp_q.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        int r;

        // Reset and power-on clear
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_row", ram_row, 0);
        check("rst_ram_col", ram_col, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 1);
        clear_all();
        repeat (129) @(posedge clk);
        #1;
        check_idle_cursor();
        check("poweron_clear_done", exp_q.size(), 0);

        // Printable, line wrap, LF, BS
        send(8'h41);
        for (int i = 0; i < 30; i++) send(8'h61 + 8'(i % 26));
        check("at_col31", cur_col, 31);
        send(8'h5A);
        send(8'h0A);
        send(8'h0D);
        for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
        send(8'h0A);
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 7; i++) send(8'h42);
        send(8'h08);
        send(8'h0A);
        send(8'h08);
        send(8'h7E);
        send(8'h7F);
        send(8'h1F);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      b = 8'($urandom_range(32, 126));
            else if (r < 80) b = (r < 75) ? 8'h0A : 8'h0D;
            else if (r < 90) b = 8'h08;
            else if (r < 93) b = 8'h0C;
            else             b = 8'($urandom_range(128, 255));
            send(b);
        end
        check("overrun_quiet", overrun, 0);

        // FF with three bytes arriving during the clear
        begin
            int bc;
            bit wr;
            model_byte(8'h0C, bc, wr);
            model_byte(8'h51, bc, wr);
            rx_data = 8'h0C; rx_valid = 1'b1;
            @(posedge clk); #1; rx_valid = 1'b0;
            check("ff_we_latency", ram_we, 1);
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #1;
                rx_data = (k == 0) ? 8'h51 : 8'h58 + 8'(k);
                rx_valid = 1'b1;
                @(posedge clk); #1;
                rx_valid = 1'b0;
            end
            check("overrun_set", overrun, 1);
            repeat (124) @(posedge clk);
            #1;
            check_idle_cursor();
            check("overrun_sticky", overrun, 1);
        end

        // Reset in the middle of a row clear
        rx_data = 8'h0A; rx_valid = 1'b1;
        mcol = 0;
        mrow = (mrow + 1) % 4;
        for (int c = 0; c < 6; c++) push_wr(mrow, c, 8'h20);
        @(posedge clk); #1; rx_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        mrow = 0;
        mcol = 0;
        check("midrst_ram_we", ram_we, 0);
        check("midrst_cur_row", cur_row, 0);
        check("midrst_cur_col", cur_col, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_pending", exp_q.size(), 0);
        clear_all();
        repeat (129) @(posedge clk);
        #1;
        check_idle_cursor();
        send(8'h21);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
